// File: rtl/tt_sweep.sv
// Exhaustive truth-table sweep engine: drives every input vector onto a combinational block
// and reports minterm count, first minterm and an optional CRC-16 signature (TT_SWEEP_MISR_EN).
`timescale 1ns/1ps
module tt_sweep #(
    parameter int N_INPUTS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  f_in,
    output logic [N_INPUTS-1:0]   vec_out,
    output logic                  busy,
    output logic                  done,
    output logic [N_INPUTS:0]     ones_count,
    output logic [N_INPUTS-1:0]   first_minterm,
    output logic                  first_valid,
    output logic [15:0]           signature
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N_INPUTS-1:0] VEC_ALL_ONES = {N_INPUTS{1'b1}};
    localparam logic [N_INPUTS-1:0] VEC_ONE      = {{(N_INPUTS-1){1'b0}}, 1'b1};
    localparam logic [N_INPUTS:0]   CNT_ONE      = {{N_INPUTS{1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_s;
    logic                  start_accept_s;
    logic                  sample_s;
    logic [N_INPUTS-1:0]   vec_r;
    logic                  busy_r;
    logic                  done_r;
    logic [N_INPUTS:0]     ones_r;
    logic [N_INPUTS-1:0]   first_r;
    logic                  first_valid_r;

    // Next-state decode; abort beats start and ends any state.
    always_comb begin
        state_s        = state_r;
        start_accept_s = 1'b0;
        sample_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (start) begin
                    state_s        = SWEEP;
                    start_accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (vec_r == VEC_ALL_ONES) begin
                    state_s  = DONE;
                    sample_s = 1'b1;
                end else begin
                    state_s  = SWEEP;
                    sample_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, status flags, vector counter and minterm results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            vec_r         <= {N_INPUTS{1'b0}};
            ones_r        <= {(N_INPUTS+1){1'b0}};
            first_r       <= {N_INPUTS{1'b0}};
            first_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == SWEEP);
            done_r  <= (state_s == DONE);
            if (start_accept_s) begin
                vec_r         <= {N_INPUTS{1'b0}};
                ones_r        <= {(N_INPUTS+1){1'b0}};
                first_r       <= {N_INPUTS{1'b0}};
                first_valid_r <= 1'b0;
            end else if (abort) begin
                vec_r <= {N_INPUTS{1'b0}};
            end else if (sample_s) begin
                // Natural wrap of the increment returns vec_out to zero after the last sample.
                vec_r <= vec_r + VEC_ONE;
                if (f_in) begin
                    ones_r <= ones_r + CNT_ONE;
                    if (!first_valid_r) begin
                        first_r       <= vec_r;
                        first_valid_r <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef TT_SWEEP_MISR_EN
    logic [15:0] sig_r;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // CRC-16 signature of the sampled output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= 16'hFFFF;
        end else if (start_accept_s) begin
            sig_r <= 16'hFFFF;
        end else if (sample_s && !abort) begin
            sig_r <= crc16_step(sig_r, f_in);
        end
    end

    assign signature = sig_r;
`else
    assign signature = 16'h0000;
`endif

    assign vec_out       = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign ones_count    = ones_r;
    assign first_minterm = first_r;
    assign first_valid   = first_valid_r;

endmodule

// File: doc/tt_sweep.md
# tt_sweep

Exhaustive truth-table sweep engine placed directly upstream of a generated N-input combinational logic block. It drives every input combination 0..2^N-1 onto the block's inputs, samples the block's single output each cycle, and reports a minterm count, the first minterm found, and a 16-bit CRC signature of the output stream. The team uses it to check generated sum-of-products netlists against their specification on silicon or in simulation without an external pattern source.

## Interface
- N_INPUTS, 12, width of the driven input vector; MSB drives input A, LSB drives the last input.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  terminate a sweep; honoured in any state.
- f_in  input  1  output of the driven combinational block, a function of vec_out only.
- vec_out  output  N_INPUTS  registered input vector to the combinational block.
- busy  output  1  high while in SWEEP.
- done  output  1  one-cycle pulse on sweep completion.
- ones_count  output  N_INPUTS+1  number of vectors with f_in=1.
- first_minterm  output  N_INPUTS  lowest vector with f_in=1.
- first_valid  output  1  first_minterm holds a valid value.
- signature  output  16  CRC-16 of the f_in stream.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE: start=1 and abort=0 -> SWEEP. On that edge: vec_out<=0, ones_count<=0, first_valid<=0, first_minterm<=0, signature<=16'hFFFF.
- SWEEP: each edge samples f_in for the current vec_out, then increments vec_out.
  - f_in=1: ones_count+=1; when first_valid=0, first_minterm<=vec_out and first_valid<=1.
  - signature update: fb=signature[15]^f_in; signature<={signature[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
  - Sample at vec_out=all-ones -> DONE; vec_out wraps to 0. No further samples are taken.
- DONE: done=1 for one cycle, then unconditionally -> IDLE.
- Results (ones_count, first_minterm, first_valid, signature) hold until the next accepted start or rst.
- abort=1 in any state -> IDLE on the next edge. done is not asserted. vec_out<=0. Partial results are held unchanged. abort wins over start in the same cycle.
- start in SWEEP or DONE is ignored and is not queued.
- ones_count cannot overflow: its maximum is 2^N_INPUTS, which fits in N_INPUTS+1 bits.

## Timing
- Reset values: vec_out=0, busy=0, done=0, ones_count=0, first_minterm=0, first_valid=0, signature=16'hFFFF, state=IDLE.
- rst has priority over start and abort. rst mid-sweep returns every output to its reset value on that edge.
- busy rises in the cycle after start is accepted, with vec_out=0 in that same cycle.
- f_in is treated as combinational from vec_out and is sampled in the same cycle vec_out is presented. The driven block therefore must meet single-cycle timing.
- SWEEP lasts exactly 2^N_INPUTS cycles.
- done is high in the cycle 2^N_INPUTS+1 cycles after the start cycle. busy is 0 in that cycle.
- Results are valid in the done cycle and every cycle after it.
- A new start is accepted in the cycle after done, giving back-to-back sweeps with one idle cycle.

## Configuration
- TT_SWEEP_MISR_EN defined: signature is computed as specified.
- TT_SWEEP_MISR_EN undefined:
  - signature is tied to 16'h0000, including during reset.
  - The CRC register and its update logic are not instantiated.
  - All other behaviour is unchanged.

## Test plan
- N_INPUTS=12, f_in tied 0, start pulse -> done after 4097 cycles. ones_count=0, first_valid=0, first_minterm=0, signature equals the model CRC of 4096 zeros.
- f_in tied 1 -> ones_count=4096, first_valid=1, first_minterm=12'h000.
- f_in = (vec_out[11:6]==vec_out[5:0]), the 6-bit equality function -> ones_count=64, first_minterm=12'h000, signature matches the model.
- f_in = (vec_out==12'hFFF) -> ones_count=1, first_minterm=12'hFFF.
- abort at sweep cycle 100 with f_in tied 1 -> no done, busy=0 next cycle, ones_count=100, vec_out=0.
  - Then: start, rst after 10 cycles -> all outputs at reset values.
- start held high continuously -> sweeps repeat with done every 4098 cycles.
  - start asserted during SWEEP has no effect on the count.
  - start and abort together in IDLE -> stays IDLE.
